// File: rtl/x86_insn_len_sequencer.sv
// Byte-serial x86-64 instruction boundary sequencer: walks prefix/REX/opcode/ModRM/SIB/
// displacement/immediate bytes and emits one length/summary record per instruction.
module x86_insn_len_sequencer #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic [8:0] opc_idx,
    input  logic       opc_has_modrm,
    input  logic [2:0] opc_imm_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_len,
    output logic [8:0] out_opc,
    output logic [7:0] out_modrm,
    output logic       out_has_modrm,
    output logic       out_rex_w,
    output logic       out_opsize,
    output logic       out_err
);

    typedef enum logic [2:0] {
        S_PREFIX,
        S_OPC2,
        S_MODRM,
        S_SIB,
        S_DISP,
        S_IMM,
        S_DONE
    } state_t;

    state_t     state, state_d;
    logic [3:0] len, len_d;
    logic [8:0] opc, opc_d;
    logic [7:0] modrm, modrm_d;
    logic       has_modrm, has_modrm_d;
    logic       rex_w, rex_w_d;
    logic       opsize, opsize_d;
    logic       err, err_d;
    logic [3:0] imm_size, imm_size_d;
    logic [3:0] remain, remain_d;
    logic [3:0] imm_now;
    logic [3:0] disp_n;
    logic       take_opc;
    logic       route;
    logic       clear;

    function automatic logic is_legacy(input logic [7:0] b);
        case (b)
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] disp_of_mod(input logic [1:0] m);
        case (m)
            2'b01:   return 4'd1;
            2'b10:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // REX.W wins over the 0x66 operand-size prefix
    always_comb begin
        case (opc_imm_code)
            3'd1:    imm_now = 4'd1;
            3'd2:    imm_now = 4'd2;
            3'd3:    imm_now = (opsize && !rex_w) ? 4'd2 : 4'd4;
            3'd4:    imm_now = 4'd4;
            3'd5:    imm_now = rex_w ? 4'd8 : (opsize ? 4'd2 : 4'd4);
            default: imm_now = 4'd0;
        endcase
    end

    always_comb begin
        state_d     = state;
        len_d       = len;
        opc_d       = opc;
        modrm_d     = modrm;
        has_modrm_d = has_modrm;
        rex_w_d     = rex_w;
        opsize_d    = opsize;
        err_d       = err;
        imm_size_d  = imm_size;
        remain_d    = remain;
        take_opc    = 1'b0;
        route       = 1'b0;
        disp_n      = 4'd0;
        clear       = 1'b0;
        in_ready    = (state != S_DONE);
        out_valid   = (state == S_DONE);
        opc_idx     = (state == S_PREFIX || state == S_OPC2) ? {state == S_OPC2, in_byte} : '0;

        if (flush) begin
            clear = 1'b1;
        end else if (state == S_DONE) begin
            clear = out_ready;
        end else if (in_valid) begin
            // the overflowing byte is swallowed and only marks the record as bad
            if (len == 4'(MAX_LEN)) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                len_d = len + 4'd1;
                case (state)
                    S_PREFIX: begin
                        if (is_legacy(in_byte)) begin
                            rex_w_d = 1'b0;
                            if (in_byte == 8'h66) opsize_d = 1'b1;
                        end else if (in_byte[7:4] == 4'h4) begin
                            rex_w_d = in_byte[3];
                        end else if (in_byte == 8'h0F) begin
                            state_d = S_OPC2;
                        end else begin
                            take_opc = 1'b1;
                        end
                    end
                    S_OPC2: begin
                        if (in_byte == 8'h38 || in_byte == 8'h3A) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            take_opc = 1'b1;
                        end
                    end
                    S_MODRM: begin
                        modrm_d = in_byte;
                        if (in_byte[7:6] != 2'b11 && in_byte[2:0] == 3'b100) begin
                            state_d = S_SIB;
                        end else begin
                            route  = 1'b1;
                            disp_n = (in_byte[7:6] == 2'b00 && in_byte[2:0] == 3'b101)
                                     ? 4'd4 : disp_of_mod(in_byte[7:6]);
                        end
                    end
                    S_SIB: begin
                        route  = 1'b1;
                        disp_n = (modrm[7:6] == 2'b00 && in_byte[2:0] == 3'b101)
                                 ? 4'd4 : disp_of_mod(modrm[7:6]);
                    end
                    S_DISP: begin
                        if (remain == 4'd1) route = 1'b1;
                        else remain_d = remain - 4'd1;
                    end
                    S_IMM: begin
                        if (remain == 4'd1) state_d = S_DONE;
                        else remain_d = remain - 4'd1;
                    end
                    default: ;
                endcase
            end
        end

        if (take_opc) begin
            opc_d       = opc_idx;
            has_modrm_d = opc_has_modrm;
            imm_size_d  = imm_now;
            if (opc_has_modrm) begin
                state_d = S_MODRM;
            end else if (imm_now != 4'd0) begin
                state_d  = S_IMM;
                remain_d = imm_now;
            end else begin
                state_d = S_DONE;
            end
        end

        if (route) begin
            if (disp_n != 4'd0) begin
                state_d  = S_DISP;
                remain_d = disp_n;
            end else if (imm_size != 4'd0) begin
                state_d  = S_IMM;
                remain_d = imm_size;
            end else begin
                state_d = S_DONE;
            end
        end

        if (clear) begin
            state_d     = S_PREFIX;
            len_d       = '0;
            opc_d       = '0;
            modrm_d     = '0;
            has_modrm_d = 1'b0;
            rex_w_d     = 1'b0;
            opsize_d    = 1'b0;
            err_d       = 1'b0;
            imm_size_d  = '0;
            remain_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_PREFIX;
            len       <= '0;
            opc       <= '0;
            modrm     <= '0;
            has_modrm <= 1'b0;
            rex_w     <= 1'b0;
            opsize    <= 1'b0;
            err       <= 1'b0;
            imm_size  <= '0;
            remain    <= '0;
        end else begin
            state     <= state_d;
            len       <= len_d;
            opc       <= opc_d;
            modrm     <= modrm_d;
            has_modrm <= has_modrm_d;
            rex_w     <= rex_w_d;
            opsize    <= opsize_d;
            err       <= err_d;
            imm_size  <= imm_size_d;
            remain    <= remain_d;
        end
    end

    assign out_len       = len;
    assign out_opc       = opc;
    assign out_modrm     = modrm;
    assign out_has_modrm = has_modrm;
    assign out_rex_w     = rex_w;
    assign out_opsize    = opsize;
    assign out_err       = err;

endmodule

// File: tb/tb_x86_insn_len_sequencer.sv
// Randomized bench for x86_insn_len_sequencer: a whole-instruction length model predicts
// every record; directed instructions pin the model to hand-computed values.
module tb_x86_insn_len_sequencer;

    typedef struct packed {
        logic [3:0] len;
        logic [8:0] opc;
        logic [7:0] modrm;
        logic       has_modrm;
        logic       rex_w;
        logic       opsize;
        logic       err;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready;
    logic [8:0] opc_idx;
    logic       opc_has_modrm;
    logic [2:0] opc_imm_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_len;
    logic [8:0] out_opc;
    logic [7:0] out_modrm;
    logic       out_has_modrm;
    logic       out_rex_w;
    logic       out_opsize;
    logic       out_err;

    bit         attr_modrm [512];
    logic [2:0] attr_imm   [512];
    logic [7:0] pfx_tab    [11] = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26,
                                    8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    rec_t seen[$];
    logic [7:0] strm[$];
    int   rdy_mode = 1;
    bit   stalls = 1'b0;

    always #5 clk = ~clk;

    assign opc_has_modrm = attr_modrm[opc_idx];
    assign opc_imm_code  = attr_imm[opc_idx];

    x86_insn_len_sequencer #(.MAX_LEN(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .opc_idx      (opc_idx),
        .opc_has_modrm(opc_has_modrm),
        .opc_imm_code (opc_imm_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_len      (out_len),
        .out_opc      (out_opc),
        .out_modrm    (out_modrm),
        .out_has_modrm(out_has_modrm),
        .out_rex_w    (out_rex_w),
        .out_opsize   (out_opsize),
        .out_err      (out_err)
    );

    function automatic rec_t mk(input int l, input int o, input int m,
                                input bit hm, input bit w, input bit osz, input bit e);
        rec_t r;
        r.len = 4'(l); r.opc = 9'(o); r.modrm = 8'(m);
        r.has_modrm = hm; r.rex_w = w; r.opsize = osz; r.err = e;
        return r;
    endfunction

    function automatic bit is_legacy(input logic [7:0] b);
        foreach (pfx_tab[i]) if (pfx_tab[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int imm_len(input logic [2:0] code, input logic w, input logic osz);
        int z;
        z = (osz && !w) ? 2 : 4;
        case (code)
            3'd1: return 1;
            3'd2: return 2;
            3'd3: return z;
            3'd4: return 4;
            3'd5: return w ? 8 : z;
            default: return 0;
        endcase
    endfunction

    // Length = prefixes + [0F] + opcode + ModRM + SIB + disp + imm, truncated at 15 bytes.
    function automatic void model(input int p0, output rec_t r, output int used);
        int k, pos_opc, pos_mr, total, disp;
        logic [7:0] b, opb, mb, sb;
        logic w, osz, esc, mr_p, sib_p;
        r = '0; w = 1'b0; osz = 1'b0; k = 0; mb = 8'h00;
        b = strm[p0];
        while (k < 15 && (is_legacy(b) || b[7:4] == 4'h4)) begin
            if (is_legacy(b)) begin
                w = 1'b0;
                if (b == 8'h66) osz = 1'b1;
            end else begin
                w = b[3];
            end
            k++;
            b = strm[p0 + k];
        end
        r.rex_w = w; r.opsize = osz;
        if (k == 15) begin
            r.len = 4'd15; r.err = 1'b1; used = 16;
            return;
        end
        esc = (b == 8'h0F);
        pos_opc = k + (esc ? 1 : 0);
        opb = strm[p0 + pos_opc];
        if (esc && (opb == 8'h38 || opb == 8'h3A)) begin
            r.err = 1'b1;
            used = pos_opc + 1;
            r.len = 4'((used > 15) ? 15 : used);
            return;
        end
        mr_p = attr_modrm[{esc, opb}];
        pos_mr = pos_opc + 1;
        sib_p = 1'b0; disp = 0;
        if (mr_p) begin
            mb = strm[p0 + pos_mr];
            sb = strm[p0 + pos_mr + 1];
            sib_p = (mb[7:6] != 2'b11 && mb[2:0] == 3'b100);
            if (mb[7:6] == 2'b01) disp = 1;
            else if (mb[7:6] == 2'b10) disp = 4;
            else if (mb[7:6] == 2'b00 && ((!sib_p && mb[2:0] == 3'b101) || (sib_p && sb[2:0] == 3'b101)))
                disp = 4;
        end
        total = pos_mr + (mr_p ? 1 : 0) + (sib_p ? 1 : 0) + disp
              + imm_len(attr_imm[{esc, opb}], w, osz);
        if (total <= 15) begin
            r.len = 4'(total); used = total;
            r.opc = {esc, opb}; r.has_modrm = mr_p; r.modrm = mr_p ? mb : 8'h00;
        end else begin
            r.len = 4'd15; r.err = 1'b1; used = 16;
            if (pos_opc < 15) begin
                r.opc = {esc, opb}; r.has_modrm = mr_p;
            end
            if (mr_p && pos_mr < 15) r.modrm = mb;
        end
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_rec(input string name, input rec_t got, input rec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got len=%0d opc=%03h modrm=%02h hm=%0b w=%0b osz=%0b err=%0b, expected len=%0d opc=%03h modrm=%02h hm=%0b w=%0b osz=%0b err=%0b",
                     name, got.len, got.opc, got.modrm, got.has_modrm, got.rex_w, got.opsize, got.err,
                     exp.len, exp.opc, exp.modrm, exp.has_modrm, exp.rex_w, exp.opsize, exp.err);
        end
    endtask

    initial begin : compare
        int unsigned vcnt;
        bit rdy;
        rec_t got;
        vcnt = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check_val("in_ready_vs_valid", {31'd0, in_ready}, {31'd0, !out_valid});
                if (out_valid === 1'b1) begin
                    got = {out_len, out_opc, out_modrm, out_has_modrm, out_rex_w, out_opsize, out_err};
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_record: got len=%0d opc=%03h, expected no record", out_len, out_opc);
                        rdy = 1'b1;
                    end else begin
                        check_rec("record", got, exp_q[0]);
                        if (rdy_mode == 2) rdy = (vcnt >= 5);
                        else if (rdy_mode == 1) rdy = 1'b1;
                        else rdy = ($urandom_range(0, 2) != 0);
                    end
                    out_ready = rdy;
                    if (rdy) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        vcnt = 0;
                    end else begin
                        vcnt++;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (stalls && $urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_byte  = b;
                if (in_ready) break;
                guard++;
                if (guard > 60) begin
                    checks++; errors++;
                    $display("FAIL byte_accept_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
                    break;
                end
            end
        end
    endtask

    task automatic run_stream(input int max_insn, input bit stl);
        int p, n, g;
        rec_t r;
        repeat (32) strm.push_back(8'h90);
        p = 0;
        seen.delete();
        while (p < strm.size() - 32 && (max_insn == 0 || seen.size() < max_insn)) begin
            model(p, r, n);
            seen.push_back(r);
            exp_q.push_back(r);
            p += n;
        end
        stalls = stl;
        for (int i = 0; i < p; i++) send_byte(strm[i]);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d records outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        strm.delete();
    endtask

    task automatic drive_raw();
        stalls = 1'b0;
        for (int i = 0; i < strm.size(); i++) send_byte(strm[i]);
        strm.delete();
    endtask

    initial begin : main
        int unsigned sel;
        for (int i = 0; i < 512; i++) begin
            attr_modrm[i] = 1'($urandom_range(0, 1));
            attr_imm[i]   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
        end
        attr_modrm[9'h090] = 1'b0; attr_imm[9'h090] = 3'd0;
        attr_modrm[9'h08B] = 1'b1; attr_imm[9'h08B] = 3'd0;
        attr_modrm[9'h1AF] = 1'b1; attr_imm[9'h1AF] = 3'd0;
        attr_modrm[9'h105] = 1'b0; attr_imm[9'h105] = 3'd0;
        attr_modrm[9'h0B8] = 1'b0; attr_imm[9'h0B8] = 3'd5;

        repeat (3) @(negedge clk);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("reset_fields", {out_len, out_opc, out_modrm, out_has_modrm, out_rex_w, out_opsize, out_err}, 32'd0);
        reset_n = 1'b1;

        rdy_mode = 1;
        strm = {8'h90};
        run_stream(1, 1'b0);
        check_rec("pin_nop", seen[0], mk(1, 'h090, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        strm = {8'h48, 8'h8B, 8'h04, 8'h25, 8'h78, 8'h56, 8'h34, 8'h12};
        run_stream(1, 1'b0);
        check_rec("pin_mov_sib_disp32", seen[0], mk(8, 'h08B, 'h04, 1'b1, 1'b1, 1'b0, 1'b0));

        strm = {8'h0F, 8'hAF, 8'hC1, 8'h0F, 8'h05};
        run_stream(2, 1'b1);
        check_rec("pin_imul_0f", seen[0], mk(3, 'h1AF, 'hC1, 1'b1, 1'b0, 1'b0, 1'b0));
        check_rec("pin_syscall", seen[1], mk(2, 'h105, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        strm = {8'h66, 8'hB8, 8'h34, 8'h12, 8'h48, 8'hB8,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_stream(2, 1'b1);
        check_rec("pin_mov_iv_16", seen[0], mk(4, 'h0B8, 0, 1'b0, 1'b0, 1'b1, 1'b0));
        check_rec("pin_mov_iv_64", seen[1], mk(10, 'h0B8, 0, 1'b0, 1'b1, 1'b0, 1'b0));

        strm = {8'h0F, 8'h38};
        run_stream(1, 1'b0);
        check_rec("pin_bad_escape", seen[0], mk(2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1));

        repeat (15) strm.push_back(8'h66);
        strm.push_back(8'h90);
        run_stream(1, 1'b0);
        check_rec("pin_overflow", seen[0], mk(15, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));

        rdy_mode = 2;
        strm = {8'h90, 8'h90};
        run_stream(2, 1'b0);
        rdy_mode = 1;

        strm = {8'h48, 8'h8B, 8'h80, 8'h11};
        drive_raw();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h22;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("flush_fields", {out_len, out_opc, out_modrm, out_has_modrm, out_rex_w, out_opsize, out_err}, 32'd0);
        strm = {8'h90};
        run_stream(1, 1'b0);
        check_rec("pin_after_flush", seen[0], mk(1, 'h090, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        strm = {8'h66, 8'h48, 8'h8B, 8'h04};
        drive_raw();
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_val("async_reset_fields", {out_len, out_opc, out_modrm, out_has_modrm, out_rex_w, out_opsize, out_err}, 32'd0);
        check_val("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        strm = {8'h90};
        run_stream(1, 1'b0);
        check_rec("pin_after_reset", seen[0], mk(1, 'h090, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        rdy_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 99);
            if (i == 700) repeat (17) strm.push_back(pfx_tab[$urandom_range(0, 10)]);
            if (sel < 12) strm.push_back(pfx_tab[$urandom_range(0, 10)]);
            else if (sel < 18) strm.push_back(8'h40 + 8'($urandom_range(0, 15)));
            else if (sel < 25) strm.push_back(8'h0F);
            else if (sel < 27) strm.push_back(($urandom_range(0, 1) == 0) ? 8'h38 : 8'h3A);
            else strm.push_back(8'($urandom));
        end
        run_stream(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of test, expected finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
